// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle of the direct-mapped data cache.
// The slave modport is the cache's view; master is the CPU/memory environment.
interface dcache_ctrl_if;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;

    // Memory handshake: mem_req_o is held until a one-cycle mem_ack_i pulse
    // completes the transaction; the cache never drops a request early
    // except under reset.
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic [127:0] mem_rdata_i;
    logic         mem_ack_i;

    logic [1:0]   fsm_state;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i,
        output fsm_state
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i,
        input  fsm_state
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Hits complete in the same cycle; misses stall while writing back and refilling.
module dcache_ctrl #(
    parameter int LINES = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    dcache_ctrl_if.slave bus
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t               state;
    logic [LINES-1:0]     valid;
    logic [LINES-1:0]     dirty;
    logic [TW-1:0]        tag_mem  [LINES];
    logic [127:0]         data_mem [LINES];

    logic                 mem_req;
    logic                 mem_we;
    logic [31:0]          mem_addr;
    logic [127:0]         mem_wdata;

    logic [IW-1:0]        idx;
    logic [TW-1:0]        req_tag;
    logic [1:0]           off;
    logic [127:0]         line;
    logic [127:0]         merged;
    logic [31:0]          word;
    logic                 hit;
    logic                 idle;
    logic                 miss;
    logic                 store_hit;
    logic                 victim_dirty;
    logic                 unused_addr;

    assign idx          = bus.cpu_addr_i[3+IW:4];
    assign req_tag      = bus.cpu_addr_i[31:4+IW];
    assign off          = bus.cpu_addr_i[3:2];
    assign unused_addr  = &{1'b0, bus.cpu_addr_i[1:0]};

    assign line         = data_mem[idx];
    assign word         = line[{off, 5'b0} +: 32];
    assign hit          = bus.cpu_req_i & valid[idx] & (tag_mem[idx] == req_tag);
    assign idle         = (state == IDLE);
    assign miss         = idle & bus.cpu_req_i & ~hit;
    assign store_hit    = idle & hit & bus.cpu_we_i;
    assign victim_dirty = valid[idx] & dirty[idx];

    always_comb begin
        merged                  = line;
        merged[{off, 5'b0} +: 32] = bus.cpu_wdata_i;
    end

    // Stall must rise in the very cycle a miss is seen, so it is decoded
    // from the live request rather than registered.
    assign bus.cpu_stall_o = ~idle | (bus.cpu_req_i & ~hit);
    assign bus.cpu_rdata_o = (idle & hit) ? word : 32'd0;

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.fsm_state   = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 128'd0;
            valid     <= '0;
            dirty     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        mem_req <= 1'b1;
                        if (victim_dirty) begin
                            state     <= WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_mem[idx], idx, 4'b0};
                            mem_wdata <= line;
                        end else begin
                            state    <= ALLOCATE;
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, idx, 4'b0};
                        end
                    end else if (store_hit) begin
                        dirty[idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ack_i) begin
                        state     <= ALLOCATE;
                        mem_we    <= 1'b0;
                        mem_addr  <= {req_tag, idx, 4'b0};
                        mem_wdata <= 128'd0;
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ack_i) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        mem_addr   <= 32'd0;
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid alone decides whether they matter.
    always_ff @(posedge clk_i) begin
        if (state == ALLOCATE && bus.mem_ack_i) begin
            data_mem[idx] <= bus.mem_rdata_i;
            tag_mem[idx]  <= req_tag;
        end else if (store_hit) begin
            data_mem[idx] <= merged;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: architectural memory model plus a per-index residency
// model predict load data, memory traffic and stall lengths.
module tb_dcache_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_ctrl_if bus();
    dcache_ctrl #(.LINES(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] data;
    } mem_txn_t;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]  exp_q[$];
    mem_txn_t     mem_exp_q[$];
    int           delay_q[$];

    logic [127:0] mem_line [logic [27:0]];
    logic [31:0]  arch     [logic [29:0]];
    bit           m_valid [16];
    bit           m_dirty [16];
    logic [23:0]  m_tag   [16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] default_line(input logic [27:0] la);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] w;
            w = i[1:0];
            l[i*32 +: 32] = {2'b10, la, w} ^ 32'h0f0f_3c3c;
        end
        return l;
    endfunction

    function automatic logic [127:0] mem_get(input logic [27:0] la);
        if (mem_line.exists(la)) return mem_line[la];
        return default_line(la);
    endfunction

    function automatic logic [31:0] arch_get(input logic [29:0] wa);
        logic [127:0] l;
        if (arch.exists(wa)) return arch[wa];
        l = mem_get(wa[29:2]);
        return l[{wa[1:0], 5'b0} +: 32];
    endfunction

    function automatic logic [127:0] arch_line(input logic [27:0] la);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] w;
            w = i[1:0];
            l[i*32 +: 32] = arch_get({la, w});
        end
        return l;
    endfunction

    function automatic int pick_delay(input int force_n);
        if (force_n > 0) return force_n;
        return int'($urandom_range(1, 4));
    endfunction

    // Issue one access and hold it until the cache stops stalling.
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, input int force_n);
        logic [3:0]  idx;
        logic [23:0] tg;
        bit          miss;
        bit          has_wb;
        int          n;
        int          exp_stall;
        int          stalls;
        bit          saw_we;
        mem_txn_t    t;
        idx = addr[7:4];
        tg  = addr[31:8];
        miss   = !(m_valid[idx] && m_tag[idx] == tg);
        has_wb = miss && m_valid[idx] && m_dirty[idx];
        exp_stall = 0;
        if (miss) begin
            exp_stall = 1;
            if (has_wb) begin
                n = pick_delay(force_n);
                delay_q.push_back(n);
                exp_stall += n;
                t.we = 1'b1;
                t.addr = {m_tag[idx], idx, 4'b0};
                t.data = arch_line({m_tag[idx], idx});
                mem_exp_q.push_back(t);
            end
            n = pick_delay(force_n);
            delay_q.push_back(n);
            exp_stall += n;
            t.we = 1'b0;
            t.addr = {tg, idx, 4'b0};
            t.data = 128'd0;
            mem_exp_q.push_back(t);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (we) begin
            arch[addr[31:2]] = wd;
            m_dirty[idx] = 1'b1;
        end else begin
            exp_q.push_back(arch_get(addr[31:2]));
        end

        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wd;
        stalls = 0;
        saw_we = 1'b0;
        #1;
        while (bus.cpu_stall_o !== 1'b0) begin
            stalls++;
            if (bus.mem_we_o) saw_we = 1'b1;
            if (stalls > 60) begin
                $display("FAIL stall_timeout: addr %0h still stalled after %0d cycles", addr, stalls);
                $fatal(1, "stall timeout");
            end
            @(negedge clk);
            #1;
        end
        check("stall_cycles", stalls, exp_stall);
        if (miss && !has_wb) check("clean_miss_no_we", saw_we, 1'b0);
        @(negedge clk);
    endtask

    task automatic go_idle(input int k);
        bus.cpu_req_i = 1'b0;
        bus.cpu_we_i  = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        arch.delete();
    endtask

    // Memory responder: acks in the n-th cycle of each request.
    initial begin
        int n;
        logic [27:0] a;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 128'd0;
        forever begin
            @(negedge clk);
            while (!rst && bus.mem_req_o) begin
                n = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
                if (n > 1) repeat (n - 1) @(negedge clk);
                a = bus.mem_addr_o[31:4];
                if (bus.mem_req_o && bus.mem_we_o) mem_line[a] = bus.mem_wdata_o;
                bus.mem_rdata_i = mem_get(a);
                bus.mem_ack_i = 1'b1;
                @(negedge clk);
                bus.mem_ack_i = 1'b0;
            end
        end
    end

    // Monitor: samples just before each rising edge.
    initial begin
        mem_txn_t t;
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                if (bus.cpu_req_i && !bus.cpu_we_i && !bus.cpu_stall_o) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL load_unexpected: got %0h expected no load", bus.cpu_rdata_o);
                    end else begin
                        check("load_data", bus.cpu_rdata_o, exp_q.pop_front());
                    end
                end else if (!bus.cpu_req_i) begin
                    check("idle_rdata", bus.cpu_rdata_o, 32'd0);
                end
                if (bus.mem_req_o && bus.mem_ack_i) begin
                    if (mem_exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL mem_unexpected: got addr %0h expected no transaction", bus.mem_addr_o);
                    end else begin
                        t = mem_exp_q.pop_front();
                        check("mem_we", bus.mem_we_o, t.we);
                        check("mem_addr", bus.mem_addr_o, t.addr);
                        if (t.we) check("mem_wdata", bus.mem_wdata_o, t.data);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        logic [31:0] a;
        rst = 1'b1;
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = 32'd0;
        bus.cpu_wdata_i = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", bus.cpu_stall_o, 1'b0);
        check("rst_rdata", bus.cpu_rdata_o, 32'd0);
        check("rst_mem_req", bus.mem_req_o, 1'b0);
        check("rst_mem_we", bus.mem_we_o, 1'b0);
        check("rst_mem_addr", bus.mem_addr_o, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata_o, 128'd0);
        check("rst_state", bus.fsm_state, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        mem_line[28'h10] = {32'd4, 32'd3, 32'd2, 32'd1};
        do_access(1'b0, 32'h0000_0100, 32'd0, 3);
        do_access(1'b1, 32'h0000_0108, 32'hDEAD_BEEF, 0);
        do_access(1'b0, 32'h0000_0108, 32'd0, 0);
        do_access(1'b0, 32'h0000_0200, 32'd0, 0);
        do_access(1'b0, 32'h0000_0300, 32'd0, 0);

        // Stray acks while idle must not start anything.
        go_idle(1);
        for (int i = 0; i < 4; i++) begin
            bus.mem_ack_i = (i % 2 == 0);
            @(negedge clk);
            #1;
            check("glitch_mem_req", bus.mem_req_o, 1'b0);
            check("glitch_state", bus.fsm_state, 2'd0);
            check("glitch_stall", bus.cpu_stall_o, 1'b0);
        end
        bus.mem_ack_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            a = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_access(1'($urandom_range(0, 1)), a, $urandom, 0);
            if ($urandom_range(0, 3) == 0) go_idle($urandom_range(1, 3));
        end

        // Reset in the middle of a long refill.
        begin
            logic [3:0]  idx;
            mem_txn_t    t;
            idx = 4'd0;
            if (m_valid[idx] && m_dirty[idx]) begin
                delay_q.push_back(1);
                t.we = 1'b1;
                t.addr = {m_tag[idx], idx, 4'b0};
                t.data = arch_line({m_tag[idx], idx});
                mem_exp_q.push_back(t);
            end
            delay_q.push_back(20);
            bus.cpu_req_i  = 1'b1;
            bus.cpu_we_i   = 1'b0;
            bus.cpu_addr_i = 32'h0000_0500;
            guard = 0;
            #1;
            while (!(bus.mem_req_o && !bus.mem_we_o) && guard < 20) begin
                @(negedge clk);
                #1;
                guard++;
            end
            check("reached_allocate", bus.mem_req_o && !bus.mem_we_o, 1'b1);
            repeat (2) @(negedge clk);
            #1;
            rst = 1'b1;
            #1;
            check("abort_mem_req", bus.mem_req_o, 1'b0);
            check("abort_mem_addr", bus.mem_addr_o, 32'd0);
            check("abort_state", bus.fsm_state, 2'd0);
            bus.cpu_req_i = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            repeat (25) @(negedge clk);
        end
        do_access(1'b0, 32'h0000_0100, 32'd0, 0);
        go_idle(4);

        check("load_q_drained", exp_q.size(), 0);
        check("mem_q_drained", mem_exp_q.size(), 0);
        check("delay_q_drained", delay_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
